// File: rtl/can_param_fifo.sv
// Parameterised synchronous message FIFO with registered or first-word-fall-through
// read port, occupancy flags and sticky overflow/underflow error reporting.
module can_param_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 4,
  parameter int FWFT       = 0,
  parameter int AFULL_LVL  = DEPTH - 1,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                        i_sys_clk,
  input  logic                        i_reset,
  input  logic                        i_wr_en,
  input  logic [DATA_WIDTH-1:0]       i_fifo_w_data,
  input  logic                        i_r_en,
  input  logic                        i_flush,
  input  logic                        i_clr_err,
  output logic [DATA_WIDTH-1:0]       o_fifo_r_data,
  output logic                        o_r_valid,
  output logic                        o_full,
  output logic                        o_empty,
  output logic                        o_almost_full,
  output logic                        o_almost_empty,
  output logic [$clog2(DEPTH):0]      o_count,
  output logic                        o_overflow,
  output logic                        o_underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_rd_acc;
  logic w_wr_acc;
  logic w_wr_do;
  logic w_rd_do;

  // Flags decode the registered count so they line up with o_count.
  assign o_count        = r_count;
  assign o_empty        = (r_count == '0);
  assign o_full         = (int'(r_count) == DEPTH);
  assign o_almost_full  = (int'(r_count) >= AFULL_LVL);
  assign o_almost_empty = (int'(r_count) <= AEMPTY_LVL);
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

  // A read frees a slot in the same cycle, so a full FIFO may still accept a write.
  assign w_rd_acc = i_r_en && !o_empty;
  assign w_wr_acc = i_wr_en && (!o_full || w_rd_acc);
  assign w_wr_do  = w_wr_acc && !i_flush && !i_reset;
  assign w_rd_do  = w_rd_acc && !i_flush;

  // NOTE: storage has no reset; validity is tracked by the pointers and count only.
  always_ff @(posedge i_sys_clk) begin
    if (w_wr_do) r_mem[r_wr_ptr] <= i_fifo_w_data;
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_wr_acc) - (AW+1)'(w_rd_acc);
    end
  end

  // NOTE: the set terms come after the clear so a new error wins over i_clr_err.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_clr_err) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end
      if (i_wr_en && !w_wr_acc && !i_flush) r_overflow  <= 1'b1;
      if (i_r_en  && !w_rd_acc && !i_flush) r_underflow <= 1'b1;
    end
  end

  generate
    if (FWFT == 0) begin : g_registered
      logic [DATA_WIDTH-1:0] r_rd_data;
      logic                  r_r_valid;

      always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
          r_rd_data <= '0;
          r_r_valid <= 1'b0;
        end else begin
          r_r_valid <= w_rd_do;
          if (w_rd_do) r_rd_data <= r_mem[r_rd_ptr];
        end
      end

      assign o_fifo_r_data = r_rd_data;
      assign o_r_valid     = r_r_valid;
    end else begin : g_fwft
      assign o_fifo_r_data = r_mem[r_rd_ptr];
      assign o_r_valid     = !o_empty;
    end
  endgenerate

endmodule

// File: tb/tb_can_param_fifo.sv
// Directed bench for can_param_fifo: a registered-read instance and a
// first-word-fall-through instance, both 4 deep by 8 bits.
module tb_can_param_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       clr;

  logic       wr0, rd0;
  logic [7:0] wd0;
  logic [7:0] rdat0;
  logic       rv0, full0, empty0, af0, ae0, ov0, un0;
  logic [2:0] cnt0;

  logic       wr1, rd1;
  logic [7:0] wd1;
  logic [7:0] rdat1;
  logic       rv1, full1, empty1, af1, ae1, ov1, un1;
  logic [2:0] cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  can_param_fifo #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(0)) dut0 (
    .i_sys_clk(clk), .i_reset(rst), .i_wr_en(wr0), .i_fifo_w_data(wd0),
    .i_r_en(rd0), .i_flush(flush), .i_clr_err(clr),
    .o_fifo_r_data(rdat0), .o_r_valid(rv0), .o_full(full0), .o_empty(empty0),
    .o_almost_full(af0), .o_almost_empty(ae0), .o_count(cnt0),
    .o_overflow(ov0), .o_underflow(un0)
  );

  can_param_fifo #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1)) dut1 (
    .i_sys_clk(clk), .i_reset(rst), .i_wr_en(wr1), .i_fifo_w_data(wd1),
    .i_r_en(rd1), .i_flush(1'b0), .i_clr_err(1'b0),
    .o_fifo_r_data(rdat1), .o_r_valid(rv1), .o_full(full1), .o_empty(empty1),
    .o_almost_full(af1), .o_almost_empty(ae1), .o_count(cnt1),
    .o_overflow(ov1), .o_underflow(un1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op0(input logic wr, input logic [7:0] d, input logic rd);
    wr0 = wr; wd0 = d; rd0 = rd;
    tick();
    wr0 = 1'b0; rd0 = 1'b0;
  endtask

  task automatic op1(input logic wr, input logic [7:0] d, input logic rd);
    wr1 = wr; wd1 = d; rd1 = rd;
    tick();
    wr1 = 1'b0; rd1 = 1'b0;
  endtask

  task automatic flags0(input string tag, input logic [2:0] c, input logic f,
                        input logic e, input logic a_f, input logic a_e);
    check({tag, ".count"}, 32'(cnt0), 32'(c));
    check({tag, ".full"},  32'(full0), 32'(f));
    check({tag, ".empty"}, 32'(empty0), 32'(e));
    check({tag, ".afull"}, 32'(af0), 32'(a_f));
    check({tag, ".aempty"}, 32'(ae0), 32'(a_e));
  endtask

  task automatic rdata0(input string tag, input logic v, input logic [7:0] d);
    check({tag, ".valid"}, 32'(rv0), 32'(v));
    check({tag, ".data"},  32'(rdat0), 32'(d));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; clr = 1'b0;
    wr0 = 1'b0; rd0 = 1'b0; wd0 = '0;
    wr1 = 1'b0; rd1 = 1'b0; wd1 = '0;
    #1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    flags0("rst", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    rdata0("rst", 1'b0, 8'h00);
    check("rst.ov", 32'(ov0), 32'd0);
    check("rst.un", 32'(un0), 32'd0);
    check("rst1.empty", 32'(empty1), 32'd1);
    check("rst1.valid", 32'(rv1), 32'd0);

    // Fill with 0x11..0x44, then drain in order with one-cycle read latency
    op0(1'b1, 8'h11, 1'b0); flags0("w1", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    op0(1'b1, 8'h22, 1'b0); flags0("w2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    op0(1'b1, 8'h33, 1'b0); flags0("w3", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    op0(1'b1, 8'h44, 1'b0); flags0("w4", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    op0(1'b0, 8'h00, 1'b1); rdata0("r1", 1'b1, 8'h11);
    op0(1'b0, 8'h00, 1'b1); rdata0("r2", 1'b1, 8'h22);
    op0(1'b0, 8'h00, 1'b1); rdata0("r3", 1'b1, 8'h33);
    op0(1'b0, 8'h00, 1'b1); rdata0("r4", 1'b1, 8'h44);
    flags0("drained", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    op0(1'b0, 8'h00, 1'b0); rdata0("idle_hold", 1'b0, 8'h44);

    // Overflow: fifth write rejected, contents intact
    op0(1'b1, 8'h11, 1'b0);
    op0(1'b1, 8'h22, 1'b0);
    op0(1'b1, 8'h33, 1'b0);
    op0(1'b1, 8'h44, 1'b0);
    op0(1'b1, 8'h55, 1'b0);
    check("ovf.flag", 32'(ov0), 32'd1);
    check("ovf.count", 32'(cnt0), 32'd4);
    op0(1'b0, 8'h00, 1'b0);
    check("ovf.sticky", 32'(ov0), 32'd1);
    op0(1'b0, 8'h00, 1'b1); rdata0("ovf.read", 1'b1, 8'h11);

    // Refill to full, then simultaneous read+write across the wrap point
    op0(1'b1, 8'h66, 1'b0);
    check("refill.count", 32'(cnt0), 32'd4);
    op0(1'b1, 8'h55, 1'b1);
    rdata0("rw_full", 1'b1, 8'h22);
    check("rw_full.count", 32'(cnt0), 32'd4);
    op0(1'b0, 8'h00, 1'b1); rdata0("drain1", 1'b1, 8'h33);
    op0(1'b0, 8'h00, 1'b1); rdata0("drain2", 1'b1, 8'h44);
    op0(1'b0, 8'h00, 1'b1); rdata0("drain3", 1'b1, 8'h66);
    op0(1'b0, 8'h00, 1'b1); rdata0("drain4", 1'b1, 8'h55);
    check("drain.empty", 32'(empty0), 32'd1);
    check("drain.un", 32'(un0), 32'd0);

    // Underflow: read+write on empty accepts the write only
    op0(1'b1, 8'hA5, 1'b1);
    check("unf.flag", 32'(un0), 32'd1);
    check("unf.count", 32'(cnt0), 32'd1);
    check("unf.valid", 32'(rv0), 32'd0);
    op0(1'b0, 8'h00, 1'b1); rdata0("unf.read", 1'b1, 8'hA5);
    clr = 1'b1; op0(1'b0, 8'h00, 1'b0); clr = 1'b0;
    check("clr.ov", 32'(ov0), 32'd0);
    check("clr.un", 32'(un0), 32'd0);
    // New error in the same cycle as clear: set wins
    clr = 1'b1; op0(1'b0, 8'h00, 1'b1); clr = 1'b0;
    check("clr_vs_set.un", 32'(un0), 32'd1);
    clr = 1'b1; op0(1'b0, 8'h00, 1'b0); clr = 1'b0;
    check("clr2.un", 32'(un0), 32'd0);

    // Flush at count 3 together with a write
    op0(1'b1, 8'h01, 1'b0);
    op0(1'b1, 8'h02, 1'b0);
    op0(1'b1, 8'h03, 1'b0);
    check("preflush.count", 32'(cnt0), 32'd3);
    flush = 1'b1; op0(1'b1, 8'h04, 1'b0); flush = 1'b0;
    flags0("flush", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("flush.ov", 32'(ov0), 32'd0);
    rdata0("flush", 1'b0, 8'hA5);
    op0(1'b1, 8'h5A, 1'b0);
    op0(1'b0, 8'h00, 1'b1); rdata0("postflush", 1'b1, 8'h5A);

    // Reset mid-stream discards entries and restores reset values
    op0(1'b1, 8'h77, 1'b0);
    op0(1'b1, 8'h88, 1'b1);
    op0(1'b1, 8'h99, 1'b1);
    check("prerst.ov_err", 32'(un0), 32'd0);
    wr0 = 1'b1; wd0 = 8'hBB; rd0 = 1'b1; flush = 1'b1; clr = 1'b1; rst = 1'b1;
    tick();
    wr0 = 1'b0; rd0 = 1'b0; flush = 1'b0; clr = 1'b0; rst = 1'b0;
    flags0("midrst", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    rdata0("midrst", 1'b0, 8'h00);
    check("midrst.ov", 32'(ov0), 32'd0);
    check("midrst.un", 32'(un0), 32'd0);

    // First-word-fall-through instance
    op1(1'b1, 8'h7E, 1'b0);
    check("fwft.valid", 32'(rv1), 32'd1);
    check("fwft.data", 32'(rdat1), 32'h7E);
    check("fwft.count", 32'(cnt1), 32'd1);
    op1(1'b0, 8'h00, 1'b1);
    check("fwft.pop_empty", 32'(empty1), 32'd1);
    check("fwft.pop_valid", 32'(rv1), 32'd0);
    op1(1'b1, 8'hA1, 1'b0);
    op1(1'b1, 8'hB2, 1'b0);
    check("fwft.head1", 32'(rdat1), 32'hA1);
    op1(1'b0, 8'h00, 1'b1);
    check("fwft.head2", 32'(rdat1), 32'hB2);
    check("fwft.head2_valid", 32'(rv1), 32'd1);
    op1(1'b0, 8'h00, 1'b1);
    op1(1'b0, 8'h00, 1'b1);
    check("fwft.un", 32'(un1), 32'd1);
    check("fwft.end_empty", 32'(empty1), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
